// File: rtl/ps2_keystroke_sequencer_if.sv
// Keystroke sequencer bus bundle.
// Groups the PS/2 byte stream, the encipher handshake, the ciphertext FIFO
// read side and the status flags of ps2_keystroke_sequencer.
//   slave  : the sequencer (consumes rx/enc/rd_en, drives codes, FIFO, status)
//   master : the surrounding system (PS2_Controller, State_Machine, consumers)
interface ps2_keystroke_sequencer_if #(
    parameter int FIFO_DEPTH = 8
);
    localparam int COUNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]         rx_data;
    logic               rx_en;
    logic [7:0]         enc_data;
    logic               enc_valid;
    logic               rd_en;
    logic [7:0]         plain_code;
    logic               plain_ext;
    logic               enc_req;
    logic               rotate;
    logic [7:0]         fifo_dout;
    logic               fifo_empty;
    logic               fifo_full;
    logic [COUNT_W-1:0] fifo_count;
    logic               overflow;
    logic               timeout_err;
    logic               busy;

    modport master (
        output rx_data, rx_en, enc_data, enc_valid, rd_en,
        input  plain_code, plain_ext, enc_req, rotate, fifo_dout, fifo_empty,
               fifo_full, fifo_count, overflow, timeout_err, busy
    );

    modport slave (
        input  rx_data, rx_en, enc_data, enc_valid, rd_en,
        output plain_code, plain_ext, enc_req, rotate, fifo_dout, fifo_empty,
               fifo_full, fifo_count, overflow, timeout_err, busy
    );
endinterface

// File: rtl/ps2_keystroke_sequencer.sv
// Keystroke make/break sequencer in front of the Enigma core.
// Decodes the PS/2 scan byte stream (make, F0 break, E0 extended), issues one
// encipher request per keystroke, opens a rotor-step window after the key's
// release and buffers ciphertext in a first-word-fall-through FIFO.
// Ports:
//   CLOCK_50 : system clock
//   reset_n  : asynchronous active-low reset
//   bus      : slave side of ps2_keystroke_sequencer_if
//              in : rx_data/rx_en, enc_data/enc_valid, rd_en
//              out: plain_code, plain_ext, enc_req, rotate, fifo_dout,
//                   fifo_empty, fifo_full, fifo_count, overflow,
//                   timeout_err, busy
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | waiting for a make code, E0 prefix or stray F0
// S_EXT     | E0 seen, next byte is an extended make (or F0 -> discard)
// S_DISCARD | drop the next byte (release of a key we never latched)
// S_ENC     | enc_req high, waiting for enc_valid or timeout
// S_HELD    | key down; typematic repeats and other keys ignored
// S_BREAK   | F0 seen while held; next byte decides if our key was released
// S_ROTATE  | rotate high for WAIT_CYCLES cycles, incoming bytes dropped
module ps2_keystroke_sequencer #(
    parameter int WAIT_CYCLES = 5000,
    parameter int ENC_TIMEOUT = 255,
    parameter int FIFO_DEPTH  = 8,
    parameter int CNT_W       = 13
) (
    input  logic                        CLOCK_50,
    input  logic                        reset_n,
    ps2_keystroke_sequencer_if.slave    bus
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [7:0] SC_EXT = 8'hE0;
    localparam logic [7:0] SC_BRK = 8'hF0;

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [PTR_W:0]   count_t;

    // The timer counts down; loading N-1 and ending at zero gives N cycles.
    localparam cnt_t   ENC_LOAD   = cnt_t'(ENC_TIMEOUT - 1);
    localparam cnt_t   WAIT_LOAD  = cnt_t'(WAIT_CYCLES - 1);
    localparam count_t DEPTH_FULL = count_t'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_EXT     = 3'd1,
        S_DISCARD = 3'd2,
        S_ENC     = 3'd3,
        S_HELD    = 3'd4,
        S_BREAK   = 3'd5,
        S_ROTATE  = 3'd6
    } state_t;

    state_t     state;
    cnt_t       cnt;
    logic [7:0] plain_code_q;
    logic       plain_ext_q;
    logic       enc_req_q;
    logic       rotate_q;
    logic       timeout_err_q;
    logic       busy_q;

    logic [7:0] mem [FIFO_DEPTH];
    ptr_t       wr_ptr;
    ptr_t       rd_ptr;
    count_t     count;
    logic       overflow_q;
    logic       empty;
    logic       full;
    logic       push;
    logic       push_ok;
    logic       pop;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            cnt           <= '0;
            plain_code_q  <= '0;
            plain_ext_q   <= 1'b0;
            enc_req_q     <= 1'b0;
            rotate_q      <= 1'b0;
            timeout_err_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.rx_en) begin
                        busy_q <= 1'b1;
                        if (bus.rx_data == SC_EXT) begin
                            state <= S_EXT;
                        end else if (bus.rx_data == SC_BRK) begin
                            state <= S_DISCARD;
                        end else begin
                            plain_code_q <= bus.rx_data;
                            plain_ext_q  <= 1'b0;
                            enc_req_q    <= 1'b1;
                            cnt          <= ENC_LOAD;
                            state        <= S_ENC;
                        end
                    end
                end
                S_EXT: begin
                    if (bus.rx_en) begin
                        if (bus.rx_data == SC_BRK) begin
                            state <= S_DISCARD;
                        end else begin
                            plain_code_q <= bus.rx_data;
                            plain_ext_q  <= 1'b1;
                            enc_req_q    <= 1'b1;
                            cnt          <= ENC_LOAD;
                            state        <= S_ENC;
                        end
                    end
                end
                S_DISCARD: begin
                    if (bus.rx_en) begin
                        busy_q <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
                S_ENC: begin
                    // enc_valid wins over a timeout landing in the same cycle
                    if (bus.enc_valid) begin
                        enc_req_q <= 1'b0;
                        state     <= S_HELD;
                    end else if (cnt == '0) begin
                        enc_req_q     <= 1'b0;
                        timeout_err_q <= 1'b1;
                        state         <= S_HELD;
                    end else begin
                        cnt <= cnt - cnt_t'(1);
                    end
                end
                S_HELD: begin
                    if (bus.rx_en && bus.rx_data == SC_BRK) begin
                        state <= S_BREAK;
                    end
                end
                S_BREAK: begin
                    if (bus.rx_en) begin
                        // Only the scan code matters; E0 of an extended
                        // release was already swallowed while held.
                        if (bus.rx_data == plain_code_q) begin
                            rotate_q <= 1'b1;
                            cnt      <= WAIT_LOAD;
                            state    <= S_ROTATE;
                        end else begin
                            state <= S_HELD;
                        end
                    end
                end
                S_ROTATE: begin
                    if (cnt == '0) begin
                        rotate_q <= 1'b0;
                        busy_q   <= 1'b0;
                        state    <= S_IDLE;
                    end else begin
                        cnt <= cnt - cnt_t'(1);
                    end
                end
                default: begin
                    enc_req_q <= 1'b0;
                    rotate_q  <= 1'b0;
                    busy_q    <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_FULL);
    assign push    = (state == S_ENC) && bus.enc_valid;
    assign pop     = bus.rd_en && !empty;
    // When full, a simultaneous pop frees the slot being written.
    assign push_ok = push && (!full || pop);

    always_ff @(posedge CLOCK_50) begin
        if (push_ok) begin
            mem[wr_ptr] <= bus.enc_data;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + ptr_t'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ptr_t'(1);
            end
            if (push && !push_ok) begin
                overflow_q <= 1'b1;
            end
            if (push_ok && !pop) begin
                count <= count + count_t'(1);
            end else if (!push_ok && pop) begin
                count <= count - count_t'(1);
            end
        end
    end

    assign bus.plain_code  = plain_code_q;
    assign bus.plain_ext   = plain_ext_q;
    assign bus.enc_req     = enc_req_q;
    assign bus.rotate      = rotate_q;
    // Head is forced to zero while empty so stale/uninitialised RAM never shows.
    assign bus.fifo_dout   = empty ? 8'h00 : mem[rd_ptr];
    assign bus.fifo_empty  = empty;
    assign bus.fifo_full   = full;
    assign bus.fifo_count  = count;
    assign bus.overflow    = overflow_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_ps2_keystroke_sequencer.sv
// Bench for ps2_keystroke_sequencer: directed scan-byte stimulus, a flag/queue
// level reference model compared every cycle, plus literal spot checks.
`timescale 1ns/1ps
module tb_ps2_keystroke_sequencer;
    localparam int W  = 6;
    localparam int T  = 10;
    localparam int D  = 4;
    localparam int CW = 8;
    localparam logic [7:0] E0 = 8'hE0;
    localparam logic [7:0] F0 = 8'hF0;

    logic CLOCK_50 = 1'b0;
    logic reset_n  = 1'b1;
    always #10 CLOCK_50 = ~CLOCK_50;

    ps2_keystroke_sequencer_if #(.FIFO_DEPTH(D)) bus_if ();

    ps2_keystroke_sequencer #(
        .WAIT_CYCLES(W), .ENC_TIMEOUT(T), .FIFO_DEPTH(D), .CNT_W(CW)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    int tests  = 0;
    int errors = 0;

    int   req_rises   = 0;
    int   rot_windows = 0;
    int   rot_cycles  = 0;
    logic prev_req    = 1'b0;
    logic prev_rot    = 1'b0;

    // Reference model: keystroke progress as flags, timers as remaining cycles.
    bit         m_prefix, m_drop, m_waiting, m_key_down, m_saw_f0;
    bit         m_ext, m_overflow, m_timeout;
    int         m_age, m_rot_left;
    logic [7:0] m_code;
    logic [7:0] m_q[$];

    bit         reply_en   = 1'b0;
    logic [7:0] reply_data = 8'h00;
    int         req_age    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        if (!reset_n) begin
            m_prefix = 0; m_drop = 0; m_waiting = 0; m_key_down = 0; m_saw_f0 = 0;
            m_ext = 0; m_overflow = 0; m_timeout = 0; m_age = 0; m_rot_left = 0;
            m_code = 8'h00;
            m_q.delete();
            return;
        end
        if (bus_if.rd_en && m_q.size() > 0) void'(m_q.pop_front());
        if (m_rot_left > 0) begin
            m_rot_left--;
        end else if (m_waiting) begin
            if (bus_if.enc_valid) begin
                if (m_q.size() < D) m_q.push_back(bus_if.enc_data);
                else m_overflow = 1;
                m_waiting = 0; m_key_down = 1; m_saw_f0 = 0;
            end else begin
                m_age++;
                if (m_age == T) begin
                    m_waiting = 0; m_timeout = 1; m_key_down = 1; m_saw_f0 = 0;
                end
            end
        end else if (m_key_down) begin
            if (bus_if.rx_en) begin
                if (m_saw_f0) begin
                    m_saw_f0 = 0;
                    if (bus_if.rx_data == m_code) begin
                        m_key_down = 0;
                        m_rot_left = W;
                    end
                end else if (bus_if.rx_data == F0) begin
                    m_saw_f0 = 1;
                end
            end
        end else if (bus_if.rx_en) begin
            if (m_drop) m_drop = 0;
            else if (bus_if.rx_data == F0) begin
                m_drop = 1; m_prefix = 0;
            end else if (bus_if.rx_data == E0 && !m_prefix) begin
                m_prefix = 1;
            end else begin
                m_code = bus_if.rx_data; m_ext = m_prefix; m_prefix = 0;
                m_waiting = 1; m_age = 0;
            end
        end
    endtask

    task automatic compare_all();
        logic [7:0] exp_dout;
        if (!reset_n) return;
        exp_dout = (m_q.size() > 0) ? m_q[0] : 8'h00;
        chk("enc_req",     32'(bus_if.enc_req),     32'(m_waiting));
        chk("rotate",      32'(bus_if.rotate),      32'(m_rot_left > 0));
        chk("busy",        32'(bus_if.busy),
            32'(m_prefix | m_drop | m_waiting | m_key_down | (m_rot_left > 0)));
        chk("plain_code",  32'(bus_if.plain_code),  32'(m_code));
        chk("plain_ext",   32'(bus_if.plain_ext),   32'(m_ext));
        chk("fifo_dout",   32'(bus_if.fifo_dout),   32'(exp_dout));
        chk("fifo_count",  32'(bus_if.fifo_count),  32'(m_q.size()));
        chk("fifo_empty",  32'(bus_if.fifo_empty),  32'(m_q.size() == 0));
        chk("fifo_full",   32'(bus_if.fifo_full),   32'(m_q.size() == D));
        chk("overflow",    32'(bus_if.overflow),    32'(m_overflow));
        chk("timeout_err", 32'(bus_if.timeout_err), 32'(m_timeout));
        if (bus_if.enc_req && !prev_req) req_rises++;
        if (bus_if.rotate && !prev_rot) rot_windows++;
        if (bus_if.rotate) rot_cycles++;
        prev_req = bus_if.enc_req;
        prev_rot = bus_if.rotate;
    endtask

    task automatic tick();
        @(negedge CLOCK_50);
        compare_all();
        @(posedge CLOCK_50);
        model_step();
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [7:0] b);
        bus_if.rx_data = b;
        bus_if.rx_en   = 1'b1;
        tick();
        bus_if.rx_en   = 1'b0;
    endtask

    task automatic pop_one();
        bus_if.rd_en = 1'b1;
        tick();
        bus_if.rd_en = 1'b0;
    endtask

    task automatic keystroke(input logic [7:0] code, input logic [7:0] cipher);
        reply_data = cipher;
        send(code);
        idle(5);
        send(F0);
        idle(1);
        send(code);
        idle(W + 2);
    endtask

    // State_Machine stand-in: answers two cycles after enc_req rises.
    initial begin
        bus_if.enc_valid = 1'b0;
        bus_if.enc_data  = 8'h00;
        forever begin
            @(posedge CLOCK_50);
            #1;
            bus_if.enc_valid = 1'b0;
            if (reset_n && bus_if.enc_req && reply_en) begin
                if (req_age == 2) begin
                    bus_if.enc_valid = 1'b1;
                    bus_if.enc_data  = reply_data;
                end
                req_age++;
            end else begin
                req_age = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, w0, c0;
        logic [7:0] drain_exp [4];
        drain_exp = '{8'hA1, 8'hA2, 8'hA3, 8'hA5};
        bus_if.rx_data = 8'h00;
        bus_if.rx_en   = 1'b0;
        bus_if.rd_en   = 1'b0;
        #5 reset_n = 1'b0;
        idle(3);
        chk("rst_enc_req",    32'(bus_if.enc_req),     32'd0);
        chk("rst_rotate",     32'(bus_if.rotate),      32'd0);
        chk("rst_busy",       32'(bus_if.busy),        32'd0);
        chk("rst_fifo_empty", 32'(bus_if.fifo_empty),  32'd1);
        chk("rst_fifo_count", 32'(bus_if.fifo_count),  32'd0);
        chk("rst_plain_code", 32'(bus_if.plain_code),  32'd0);
        chk("rst_flags",      32'({bus_if.overflow, bus_if.timeout_err, bus_if.fifo_full}), 32'd0);
        reset_n = 1'b1;
        idle(2);

        // Press/release "A"
        reply_en = 1'b1;
        reply_data = 8'h51;
        r0 = req_rises; w0 = rot_windows; c0 = rot_cycles;
        send(8'h1C);
        chk("A_req_latency", 32'(bus_if.enc_req),    32'd1);
        chk("A_plain_code",  32'(bus_if.plain_code), 32'h1C);
        idle(5);
        chk("A_plain_ext",   32'(bus_if.plain_ext),  32'd0);
        chk("A_fifo_dout",   32'(bus_if.fifo_dout),  32'h51);
        chk("A_fifo_count",  32'(bus_if.fifo_count), 32'd1);
        pop_one();
        send(F0);
        idle(1);
        send(8'h1C);
        chk("A_rotate_on",   32'(bus_if.rotate),     32'd1);
        idle(W + 2);
        chk("A_reqs",        32'(req_rises - r0),    32'd1);
        chk("A_windows",     32'(rot_windows - w0),  32'd1);
        chk("A_rot_cycles",  32'(rot_cycles - c0),   32'(W));

        // Extended key
        reply_data = 8'h62;
        r0 = req_rises; w0 = rot_windows;
        send(E0); idle(1); send(8'h75); idle(5);
        chk("X_plain_ext",  32'(bus_if.plain_ext),  32'd1);
        chk("X_plain_code", 32'(bus_if.plain_code), 32'h75);
        send(E0); idle(1); send(F0); idle(1); send(8'h75);
        idle(W + 2);
        chk("X_reqs",    32'(req_rises - r0),   32'd1);
        chk("X_windows", 32'(rot_windows - w0), 32'd1);
        pop_one();

        // Typematic repeat
        reply_data = 8'h33;
        r0 = req_rises; w0 = rot_windows;
        send(8'h1C); idle(5);
        repeat (4) begin send(8'h1C); idle(1); end
        send(F0); idle(1); send(8'h1C);
        idle(W + 2);
        chk("R_reqs",       32'(req_rises - r0),    32'd1);
        chk("R_windows",    32'(rot_windows - w0),  32'd1);
        chk("R_fifo_count", 32'(bus_if.fifo_count), 32'd1);
        pop_one();

        // Timeout
        reply_en = 1'b0;
        w0 = rot_windows;
        send(8'h2D);
        idle(T - 1);
        chk("T_not_yet",    32'(bus_if.timeout_err), 32'd0);
        tick();
        chk("T_timeout",    32'(bus_if.timeout_err), 32'd1);
        chk("T_fifo_empty", 32'(bus_if.fifo_empty),  32'd1);
        chk("T_enc_req",    32'(bus_if.enc_req),     32'd0);
        send(F0); idle(1); send(8'h2D);
        idle(W + 2);
        chk("T_windows",    32'(rot_windows - w0),   32'd1);
        reply_en = 1'b1;

        // FIFO fill and overflow
        keystroke(8'h15, 8'hA0);
        keystroke(8'h1D, 8'hA1);
        keystroke(8'h24, 8'hA2);
        keystroke(8'h2D, 8'hA3);
        keystroke(8'h2C, 8'hA4);
        chk("F_full",      32'(bus_if.fifo_full),  32'd1);
        chk("F_count",     32'(bus_if.fifo_count), 32'(D));
        chk("F_overflow",  32'(bus_if.overflow),   32'd1);
        chk("F_head",      32'(bus_if.fifo_dout),  32'hA0);
        reply_data = 8'hA5;
        send(8'h35);
        tick(); tick();
        bus_if.rd_en = 1'b1;
        tick();
        bus_if.rd_en = 1'b0;
        idle(2);
        chk("F_pushpop_count", 32'(bus_if.fifo_count), 32'(D));
        chk("F_pushpop_head",  32'(bus_if.fifo_dout),  32'hA1);
        send(F0); idle(1); send(8'h35);
        idle(W + 2);
        for (int i = 0; i < 4; i++) begin
            chk("F_drain", 32'(bus_if.fifo_dout), 32'(drain_exp[i]));
            pop_one();
        end
        chk("F_drained_empty", 32'(bus_if.fifo_empty), 32'd1);

        // Reset mid-ROTATE
        reply_data = 8'h77;
        send(8'h4D); idle(5);
        send(F0); idle(1); send(8'h4D);
        idle(2);
        chk("Z_rotating", 32'(bus_if.rotate), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("Z_rotate",     32'(bus_if.rotate),     32'd0);
        chk("Z_busy",       32'(bus_if.busy),       32'd0);
        chk("Z_fifo_count", 32'(bus_if.fifo_count), 32'd0);
        chk("Z_fifo_empty", 32'(bus_if.fifo_empty), 32'd1);
        idle(2);
        reset_n = 1'b1;
        idle(2);

        // Stray break in IDLE
        r0 = req_rises;
        send(F0); idle(1); send(8'h1C);
        idle(3);
        chk("S_reqs",    32'(req_rises - r0),  32'd0);
        chk("S_busy",    32'(bus_if.busy),     32'd0);
        chk("S_enc_req", 32'(bus_if.enc_req),  32'd0);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
